// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS execute stage: op codes, FSM encoding and default widths.
package ex_pkg;

  localparam int DEF_W    = 32;
  localparam int DEF_ITER = 32;
  localparam int OP_W     = 5;

  localparam logic [OP_W-1:0] OP_ADD   = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 5'd1;
  localparam logic [OP_W-1:0] OP_AND   = 5'd2;
  localparam logic [OP_W-1:0] OP_OR    = 5'd3;
  localparam logic [OP_W-1:0] OP_XOR   = 5'd4;
  localparam logic [OP_W-1:0] OP_NOR   = 5'd5;
  localparam logic [OP_W-1:0] OP_SLT   = 5'd6;
  localparam logic [OP_W-1:0] OP_SLTU  = 5'd7;
  localparam logic [OP_W-1:0] OP_SLL   = 5'd8;
  localparam logic [OP_W-1:0] OP_SRL   = 5'd9;
  localparam logic [OP_W-1:0] OP_SRA   = 5'd10;
  localparam logic [OP_W-1:0] OP_LUI   = 5'd11;
  localparam logic [OP_W-1:0] OP_MFHI  = 5'd12;
  localparam logic [OP_W-1:0] OP_MFLO  = 5'd13;
  localparam logic [OP_W-1:0] OP_MULT  = 5'd14;
  localparam logic [OP_W-1:0] OP_MULTU = 5'd15;
  localparam logic [OP_W-1:0] OP_DIV   = 5'd16;
  localparam logic [OP_W-1:0] OP_DIVU  = 5'd17;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// Iterative 32-step multiply / restoring-divide unit for ex_stage.
// Only compiled when EX_MULDIV_EN is defined.
`ifdef EX_MULDIV_EN
module ex_muldiv_unit
  import ex_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int ITER = DEF_ITER
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_div,
  input  logic         i_signed,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_done,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  localparam int CNT_W = $clog2(ITER + 1);

  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     acc_hi, acc_lo, opnd, a_raw;
  logic             is_div, neg_q, neg_r, div0, ovf;
  logic [W-1:0]     mag_a, mag_b;
  logic [W:0]       mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [W-1:0]     hi_n, lo_n;
  logic [2*W-1:0]   prod;

  assign mag_a = (i_signed && i_a[W-1]) ? -i_a : i_a;
  assign mag_b = (i_signed && i_b[W-1]) ? -i_b : i_b;

  // one iteration: {acc_hi,acc_lo} is the product for mul, {remainder,quotient} for div
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[W-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = ~div_diff[W];
    if (is_div) begin
      hi_n = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
      lo_n = {acc_lo[W-2:0], div_ge};
    end else begin
      hi_n = mul_sum[W:1];
      lo_n = {mul_sum[0], acc_lo[W-1:1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_start) begin
      cnt <= CNT_W'(ITER);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_start) begin
      acc_hi <= '0;
      acc_lo <= mag_a;
      opnd   <= mag_b;
      a_raw  <= i_a;
      is_div <= i_div;
      neg_q  <= i_signed & (i_a[W-1] ^ i_b[W-1]);
      neg_r  <= i_signed & i_a[W-1];
      div0   <= i_div & (i_b == '0);
      ovf    <= i_div & i_signed & (i_a == {1'b1, {(W-1){1'b0}}}) & (i_b == '1);
    end else if (cnt != '0) begin
      acc_hi <= hi_n;
      acc_lo <= lo_n;
    end
  end

  assign o_done = (cnt == CNT_W'(1));

  // results are taken from the final step directly so HI/LO land on the same edge
  always_comb begin
    prod = {hi_n, lo_n};
    if (neg_q) prod = -prod;
    o_hi = prod[2*W-1:W];
    o_lo = prod[W-1:0];
    if (is_div) begin
      o_lo = neg_q ? -lo_n : lo_n;
      o_hi = neg_r ? -hi_n : hi_n;
      if (div0) begin
        o_lo = '1;
        o_hi = a_raw;
      end else if (ovf) begin
        o_lo = {1'b1, {(W-1){1'b0}}};
        o_hi = '0;
      end
    end
  end

endmodule
`endif

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, HI/LO and registered EX/MEM result path.
// Define EX_MULDIV_EN to build the iterative MULT/MULTU/DIV/DIVU unit.
module ex_stage
  import ex_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int ITER = DEF_ITER
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [OP_W-1:0] i_op,
  input  logic            i_use_imm,
  input  logic [W-1:0]    i_a,
  input  logic [W-1:0]    i_b,
  input  logic [25:0]     i_imm,
  input  logic [4:0]      i_rd,
  input  logic [W-1:0]    i_pc_inc,
  output logic            o_valid,
  output logic [W-1:0]    o_result,
  output logic [4:0]      o_rd,
  output logic [W-1:0]    o_pc_inc,
  output logic            o_stall
);

  logic [W-1:0]        b_eff, alu_res, hi_q, lo_q;
  logic signed [W-1:0] a_s, b_s;
  logic [4:0]          shamt;
  logic                alu_wb;
  logic                unused_bits;

  assign b_eff       = i_use_imm ? {{(W-16){i_imm[15]}}, i_imm[15:0]} : i_b;
  assign a_s         = i_a;
  assign b_s         = b_eff;
  assign shamt       = i_imm[10:6];
  assign unused_bits = ^i_imm[25:16];

  // p0: combinational ALU on the ID/EX operands
  always_comb begin
    alu_res = '0;
    alu_wb  = 1'b1;
    case (i_op)
      OP_ADD:  alu_res = i_a + b_eff;
      OP_SUB:  alu_res = i_a - b_eff;
      OP_AND:  alu_res = i_a & b_eff;
      OP_OR:   alu_res = i_a | b_eff;
      OP_XOR:  alu_res = i_a ^ b_eff;
      OP_NOR:  alu_res = ~(i_a | b_eff);
      OP_SLT:  alu_res = {{(W-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: alu_res = {{(W-1){1'b0}}, (i_a < b_eff)};
      OP_SLL:  alu_res = i_a << shamt;
      OP_SRL:  alu_res = i_a >> shamt;
      OP_SRA:  alu_res = a_s >>> shamt;
      OP_LUI:  alu_res = {i_imm[15:0], {(W-16){1'b0}}};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_wb  = 1'b0;
    endcase
  end

`ifdef EX_MULDIV_EN
  logic [0:0]   state;
  logic         is_md, md_start, md_done;
  logic [W-1:0] md_hi, md_lo;

  assign is_md    = (i_op >= OP_MULT) && (i_op <= OP_DIVU);
  assign md_start = (state == ST_IDLE) && i_valid && is_md;

  ex_muldiv_unit #(.W(W), .ITER(ITER)) u_muldiv (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (md_start),
    .i_div    ((i_op == OP_DIV) || (i_op == OP_DIVU)),
    .i_signed ((i_op == OP_MULT) || (i_op == OP_DIV)),
    .i_a      (i_a),
    .i_b      (b_eff),
    .o_done   (md_done),
    .o_hi     (md_hi),
    .o_lo     (md_lo)
  );
`else
  logic unused_iter;

  assign unused_iter = ITER[0];
  assign hi_q        = '0;
  assign lo_q        = '0;
  assign o_stall     = 1'b0;
`endif

  // p1: EX/MEM register, HI/LO and FSM
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_rd     <= '0;
      o_pc_inc <= '0;
`ifdef EX_MULDIV_EN
      state    <= ST_IDLE;
      o_stall  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`endif
    end else begin
      o_valid <= 1'b0;
`ifdef EX_MULDIV_EN
      if (state == ST_BUSY) begin
        if (md_done) begin
          hi_q     <= md_hi;
          lo_q     <= md_lo;
          state    <= ST_IDLE;
          o_stall  <= 1'b0;
          o_valid  <= 1'b1;
          o_result <= '0;
          o_rd     <= '0;
        end
      end else if (i_valid && is_md) begin
        state   <= ST_BUSY;
        o_stall <= 1'b1;
      end else
`endif
      if (i_valid) begin
        o_valid  <= 1'b1;
        o_result <= alu_res;
        o_rd     <= alu_wb ? i_rd : 5'd0;
        o_pc_inc <= i_pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with a cycle-level reference model; adapts to EX_MULDIV_EN.
module tb_ex_stage;
  import ex_pkg::*;

`ifdef EX_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [4:0]  i_op = '0;
  logic        i_use_imm = 1'b0;
  logic [31:0] i_a = '0, i_b = '0, i_pc_inc = '0;
  logic [25:0] i_imm = '0;
  logic [4:0]  i_rd = '0;
  logic        o_valid, o_stall;
  logic [31:0] o_result, o_pc_inc;
  logic [4:0]  o_rd;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  ex_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_op(i_op),
    .i_use_imm(i_use_imm), .i_a(i_a), .i_b(i_b), .i_imm(i_imm), .i_rd(i_rd),
    .i_pc_inc(i_pc_inc), .o_valid(o_valid), .o_result(o_result), .o_rd(o_rd),
    .o_pc_inc(o_pc_inc), .o_stall(o_stall)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] md_expect(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    int sa, sb;
    pa = $signed(a);
    pb = $signed(b);
    sa = a;
    sb = b;
    case (op)
      OP_MULT:  return pa * pb;
      OP_MULTU: return {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] alu_expect(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                             input logic [25:0] imm, input logic [31:0] hi, input logic [31:0] lo);
    int unsigned sh;
    sh = imm[10:6];
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return $signed(a) >>> sh;
      OP_LUI:  return {imm[15:0], 16'h0};
      OP_MFHI: return hi;
      OP_MFLO: return lo;
      default: return 32'h0;
    endcase
  endfunction

  logic        m_valid = 0, m_stall = 0, m_pc_chk = 0;
  logic [31:0] m_result = 0, m_pc = 0, m_hi = 0, m_lo = 0;
  logic [4:0]  m_rd = 0;
  logic [63:0] m_pend = 0;
  int          m_busy = 0;

  always @(posedge i_clk) begin : model
    logic [31:0] beff;
    beff = i_use_imm ? {{16{i_imm[15]}}, i_imm[15:0]} : i_b;
    if (!i_rst_n) begin
      m_valid <= 0; m_result <= 0; m_rd <= 0; m_pc <= 0; m_stall <= 0;
      m_hi <= 0; m_lo <= 0; m_busy <= 0; m_pc_chk <= 0;
    end else if (m_busy > 0) begin
      m_busy  <= m_busy - 1;
      m_valid <= 0;
      if (m_busy == 1) begin
        m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0];
        m_valid <= 1; m_result <= 0; m_rd <= 0; m_stall <= 0; m_pc_chk <= 0;
      end
    end else if (i_valid && MD && i_op >= OP_MULT && i_op <= OP_DIVU) begin
      m_pend <= md_expect(i_op, i_a, beff);
      m_busy <= 32; m_stall <= 1; m_valid <= 0;
    end else if (i_valid) begin
      m_valid  <= 1;
      m_result <= alu_expect(i_op, i_a, beff, i_imm, m_hi, m_lo);
      m_rd     <= (i_op <= OP_MFLO) ? i_rd : 5'd0;
      m_pc     <= i_pc_inc;
      m_pc_chk <= 1;
    end else begin
      m_valid <= 0;
    end
  end

  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("mdl_valid", 32'(o_valid), 32'(m_valid));
      chk("mdl_stall", 32'(o_stall), 32'(m_stall));
      if (m_valid) begin
        chk("mdl_result", o_result, m_result);
        chk("mdl_rd", 32'(o_rd), 32'(m_rd));
        if (m_pc_chk) chk("mdl_pc", o_pc_inc, m_pc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [25:0] imm, input logic use_imm, input logic [4:0] rd);
    @(negedge i_clk);
    i_op = op; i_a = a; i_b = b; i_imm = imm; i_use_imm = use_imm; i_rd = rd;
    i_pc_inc = i_pc_inc + 32'd4;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int k;
    @(negedge i_clk);
    i_op = op; i_a = a; i_b = b; i_use_imm = 1'b0; i_imm = '0; i_rd = 5'd9;
    i_pc_inc = i_pc_inc + 32'd4;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_op = OP_MFLO; i_rd = 5'd2; i_pc_inc = i_pc_inc + 32'd4;
    k = 0;
    while (o_stall === 1'b1 && k < 60) begin
      k++;
      @(negedge i_clk);
    end
    chk({name, "_stall_cycles"}, 32'(k), MD ? 32'd32 : 32'd0);
    chk({name, "_done_valid"}, 32'(o_valid), 32'd1);
    chk({name, "_done_rd"}, 32'(o_rd), 32'd0);
    @(negedge i_clk);
    chk({name, "_mflo"}, o_result, exp_lo);
    i_op = OP_MFHI; i_rd = 5'd3; i_pc_inc = i_pc_inc + 32'd4;
    @(negedge i_clk);
    chk({name, "_mfhi"}, o_result, exp_hi);
    i_valid = 1'b0;
  endtask

  initial begin
    int pulses;
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_rd", 32'(o_rd), 32'd0);
    chk("rst_pc", o_pc_inc, 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    cmp_en = 1'b1;
    i_rst_n = 1'b1;

    issue(OP_ADD, 32'd7, 32'hFFFF_FFFE, 26'h0, 1'b0, 5'd3);
    chk("add_result", o_result, 32'd5);
    chk("add_valid", 32'(o_valid), 32'd1);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 26'h0, 1'b0, 5'd4);
    chk("slt_result", o_result, 32'd1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 26'h0, 1'b0, 5'd4);
    chk("sltu_result", o_result, 32'd0);
    issue(OP_ADD, 32'd0, 32'h1234_5678, 26'h8000, 1'b1, 5'd5);
    chk("addi_result", o_result, 32'hFFFF_8000);
    issue(OP_SRA, 32'h8000_0000, 32'd0, 26'h100, 1'b0, 5'd6);
    chk("sra_result", o_result, 32'hF800_0000);
    issue(OP_SRL, 32'h8000_0000, 32'd0, 26'h100, 1'b0, 5'd6);
    chk("srl_result", o_result, 32'h0800_0000);
    issue(OP_SLL, 32'd1, 32'd0, 26'h7C0, 1'b0, 5'd7);
    chk("sll_result", o_result, 32'h8000_0000);
    issue(OP_SUB, 32'd3, 32'd5, 26'h0, 1'b0, 5'd8);
    chk("sub_result", o_result, 32'hFFFF_FFFE);
    issue(OP_NOR, 32'h0F0F_0000, 32'h00F0_000F, 26'h0, 1'b0, 5'd8);
    chk("nor_result", o_result, 32'hF000_FFF0);
    issue(OP_LUI, 32'd0, 32'd0, 26'h1234, 1'b0, 5'd9);
    chk("lui_result", o_result, 32'h1234_0000);
    issue(5'd20, 32'd1, 32'd2, 26'h0, 1'b0, 5'd7);
    chk("nop_valid", 32'(o_valid), 32'd1);
    chk("nop_rd", 32'(o_rd), 32'd0);

    // back-to-back single-cycle ops
    @(negedge i_clk);
    i_valid = 1'b1; i_use_imm = 1'b0; i_rd = 5'd10;
    i_op = OP_AND; i_a = 32'hF0F0_1234; i_b = 32'hFF00_FF00; i_pc_inc = i_pc_inc + 32'd4;
    @(negedge i_clk);
    i_op = OP_OR; i_pc_inc = i_pc_inc + 32'd4;
    @(negedge i_clk);
    chk("burst_or", o_result, 32'hFFF0_FF34);
    i_op = OP_XOR; i_pc_inc = i_pc_inc + 32'd4;
    @(negedge i_clk);
    i_op = OP_ADD; i_use_imm = 1'b1; i_imm = 26'h7FFF; i_pc_inc = i_pc_inc + 32'd4;
    @(negedge i_clk);
    i_valid = 1'b0; i_use_imm = 1'b0;
    @(negedge i_clk);

    run_md(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult", MD ? 32'hFFFF_FFF1 : 32'h0, MD ? 32'hFFFF_FFFF : 32'h0);
    run_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div", MD ? 32'hFFFF_FFFD : 32'h0, MD ? 32'hFFFF_FFFF : 32'h0);
    run_md(OP_DIVU, 32'd9, 32'd0, "divu0", MD ? 32'hFFFF_FFFF : 32'h0, MD ? 32'd9 : 32'h0);
    run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "divovf", MD ? 32'h8000_0000 : 32'h0, 32'h0);
    run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu", MD ? 32'h0000_0001 : 32'h0, MD ? 32'hFFFF_FFFE : 32'h0);
    run_md(OP_DIV, 32'd7, 32'hFFFF_FFFE, "divneg", MD ? 32'hFFFF_FFFD : 32'h0, MD ? 32'd1 : 32'h0);
    run_md(OP_DIVU, 32'd100, 32'd7, "divu", MD ? 32'd14 : 32'h0, MD ? 32'd2 : 32'h0);

    // reset in the middle of a divide
    @(negedge i_clk);
    i_op = OP_DIVU; i_a = 32'd9; i_b = 32'd2; i_rd = 5'd1; i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("abort_stall", 32'(o_stall), 32'd0);
    i_rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 32'd0);
    issue(OP_MFHI, 32'd0, 32'd0, 26'h0, 1'b0, 5'd2);
    chk("abort_hi", o_result, 32'd0);
    issue(OP_MFLO, 32'd0, 32'd0, 26'h0, 1'b0, 5'd2);
    chk("abort_lo", o_result, 32'd0);

    repeat (2) @(negedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, sitting directly downstream of the ID/EX pipeline register and driving the EX/MEM boundary.
- Computes ALU results from the registered A/B operands and the immediate field.
- Owns the HI/LO registers.
- Runs MULT/MULTU/DIV/DIVU on an iterative 32-cycle unit, stalling the upstream pipeline while it is busy.
- All outputs are registered, so the block also serves as the EX/MEM register for the result path.

## Interface
Parameters:
- W, 32, datapath width; only 32 is supported.
- ITER, 32, mul/div iteration count; fixed equal to W.

Ports:
- Clock and reset: one clock, `i_clk`; reset `i_rst_n` is synchronous and active-low.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  ID/EX holds a valid instruction.
- i_op  in  5  operation code (ex_pkg).
- i_use_imm  in  1  B source = sign-extended i_imm[15:0] instead of i_b.
- i_a  in  32  A operand.
- i_b  in  32  B operand.
- i_imm  in  26  immediate field; [10:6] is the shift amount.
- i_rd  in  5  destination register.
- i_pc_inc  in  32  incremented PC, passed through.
- o_valid  out  1  result valid for EX/MEM.
- o_result  out  32  ALU / HI / LO result.
- o_rd  out  5  destination; 0 means no writeback.
- o_pc_inc  out  32  registered i_pc_inc.
- o_stall  out  1  upstream must hold ID/EX and IF/ID.

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU
  - 8 SLL, 9 SRL, 10 SRA (shift by i_imm[10:6]), 11 LUI ({imm[15:0],16'h0})
  - 12 MFHI, 13 MFLO, 14 MULT, 15 MULTU, 16 DIV, 17 DIVU
  - others: NOP (o_valid=1, o_rd=0, o_result=0)
- Arithmetic wraps modulo 2^32; no overflow trap.
- SLT compares signed, SLTU unsigned; the result is 0 or 1.
- FSM states:
  - IDLE: accepts an instruction when i_valid=1.
    - Single-cycle ops (0–13) are registered at the next edge.
    - Ops 14–17 latch the operands and move to BUSY with count=ITER.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; count decrements each cycle. When count reaches 1, the next edge writes HI/LO and returns to IDLE.
- Signed mul/div: operate on magnitudes, then fix signs.
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero: LO=32'hFFFF_FFFF, HI=i_a, for both DIV and DIVU.
- DIV of 32'h8000_0000 by 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- Completion of a mul/div produces one o_valid pulse with o_rd=0 and o_result=0.
- MULT: HI=upper 32 bits, LO=lower 32 bits of the product. DIV: LO=quotient, HI=remainder.
- i_valid is ignored while in BUSY.
- Reset values: o_valid=0, o_result=0, o_rd=0, o_pc_inc=0, o_stall=0, HI=LO=0, state=IDLE.
- Reset asserted during BUSY aborts the operation; HI/LO are cleared and no completion pulse is produced.

## Timing
- Single-cycle op accepted at edge N: o_valid=1 with its result during cycle N+1.
- Back-to-back single-cycle ops sustain 1 per cycle.
- Mul/div accepted at edge N:
  - o_stall=1 and o_valid=0 for cycles N+1 through N+32.
  - HI/LO are updated at edge N+32.
  - Completion pulse: o_valid=1 in cycle N+33; o_stall=0 from cycle N+33.
- The instruction held by ID/EX during the stall is accepted at the first edge where o_stall=0.
- An MFHI/MFLO following a mul/div therefore reads the updated HI/LO.
- o_stall is a registered decode of state (state != IDLE); it has no combinational path from inputs.

## Configuration
- EX_MULDIV_EN defined: the iterative unit and ops 14–17 behave as above.
- EX_MULDIV_EN undefined:
  - The unit is not instantiated and o_stall is tied to 0.
  - Ops 14–17 act as NOP and HI/LO never change.
  - MFHI/MFLO return 0.

## Structure
- Package ex_pkg holds:
  - op code localparams (OP_ADD … OP_DIVU) and the 5-bit op width;
  - the FSM state encoding (ST_IDLE, ST_BUSY);
  - the default W and ITER values.
- Sub-module ex_muldiv_unit, instantiated only under EX_MULDIV_EN, contains:
  - the count and operand/accumulator shift registers;
  - sign handling and the divide-by-zero and overflow cases;
  - a start/done handshake to the parent.
- The ALU, HI/LO registers, FSM and output registers live in ex_stage.

## Test plan
- After reset: ADD a=7, b=32'hFFFF_FFFE -> o_result=5, o_valid=1 in the next cycle; then SLT a=-1, b=1 -> 1; SLTU with the same operands -> 0.
- i_use_imm=1, i_imm[15:0]=16'h8000, ADD a=0 -> 32'hFFFF_8000; SRA of a=32'h8000_0000 with shamt=4 -> 32'hF800_0000.
- MULT a=-3, b=5 -> o_stall high for exactly 32 cycles, then MFLO -> 32'hFFFF_FFF1 and MFHI -> 32'hFFFF_FFFF.
- DIV a=-7, b=2 -> LO=-3, HI=-1; DIVU a=9, b=0 -> LO=32'hFFFF_FFFF, HI=9.
- Reset asserted 10 cycles into a DIVU -> o_stall=0 the next cycle, no completion pulse, HI=LO=0.
- Build without EX_MULDIV_EN: MULT a=3, b=3 -> o_stall is never asserted; MFLO -> 0.
